// File: rtl/snes_pkg.sv
// Shared encodings and timing constants for the SNES controller emulator.
// Combinational helpers only; no latency, no flow control.
package snes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_SHIFT = 2'd2
   } snes_state_t;

   localparam int SNES_BITS = 16;
   localparam int BTN_BITS  = 12;
   localparam int DELAY_12U = 600;
   localparam int DELAY_6U  = 300;

   // Bit index whose console clock rising edge ends the frame.
   localparam logic [3:0] LAST_BIT = 4'd14;
   localparam logic [3:0] MAX_BIT  = 4'd15;

   function automatic logic [SNES_BITS-1:0] load_word(input logic [BTN_BITS-1:0] btn,
                                                      input logic                fill);
      return {{(SNES_BITS - BTN_BITS){fill}}, btn};
   endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// 2-FF synchronizer plus edge-detect register for one asynchronous console line.
// Level valid 2 clk after the input edge, rise/fall pulses in the same cycle; no flow control.
module snes_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta   <= RST_VAL;
         sync   <= RST_VAL;
         sync_d <= RST_VAL;
      end else begin
         meta   <= din;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~sync_d;
   assign fall  = ~sync & sync_d;

endmodule

// File: rtl/snes_controller_emu.sv
// Emulates an SNES pad: latches 12 buttons and shifts them out on console clock rising edges.
// data settles 3 clk after a console edge; the console cannot stall it, aborts come from latch or timeout.
module snes_controller_emu
   import snes_pkg::*;
#(
   parameter int   TIMEOUT_CYCLES = 2000,
   parameter logic FILL           = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          latch,
   input  logic          clock,
   input  logic [11:0]   buttons,
   output logic          data,
   output logic          busy,
   output logic [3:0]    bit_count,
   output logic          frame_done,
   output logic          timeout
);

   localparam int             TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYCLES);

   logic lat_lvl, lat_rise, lat_fall;
   logic clk_lvl, clk_rise, clk_fall;

   snes_sync_edge #(.RST_VAL(1'b0)) u_latch_sync (
      .clk   (clk),
      .reset (reset),
      .din   (latch),
      .level (lat_lvl),
      .rise  (lat_rise),
      .fall  (lat_fall)
   );

   // Clock idles high, so resetting its pipe to 1 avoids a phantom rise after reset.
   snes_sync_edge #(.RST_VAL(1'b1)) u_clock_sync (
      .clk   (clk),
      .reset (reset),
      .din   (clock),
      .level (clk_lvl),
      .rise  (clk_rise),
      .fall  (clk_fall)
   );

   // Console clock falls and the latch rise pulse are deliberately not acted on.
   logic unused_sync;
   assign unused_sync = &{1'b0, clk_lvl, clk_fall, lat_rise};

   snes_state_t           state, nxt_state;
   logic [SNES_BITS-1:0]  shreg, nxt_shreg;
   logic [3:0]            bit_cnt, nxt_bit_cnt;
   logic [TW-1:0]         tcnt, nxt_tcnt;
   logic                  done_set, tmo_set;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state   = state;
      nxt_shreg   = shreg;
      nxt_bit_cnt = bit_cnt;
      nxt_tcnt    = tcnt;
      done_set    = 1'b0;
      tmo_set     = 1'b0;
      if (lat_lvl) begin
         // Latch wins over everything, including a same-cycle clock edge.
         nxt_state   = ST_LATCH;
         nxt_shreg   = load_word(buttons, FILL);
         nxt_bit_cnt = 4'd0;
         nxt_tcnt    = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               nxt_bit_cnt = 4'd0;
               nxt_tcnt    = '0;
            end
            ST_LATCH: begin
               nxt_bit_cnt = 4'd0;
               nxt_tcnt    = '0;
               if (lat_fall) begin
                  nxt_state = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (clk_rise) begin
                  nxt_shreg = {FILL, shreg[SNES_BITS-1:1]};
                  nxt_tcnt  = '0;
                  if (bit_cnt != MAX_BIT) begin
                     nxt_bit_cnt = bit_cnt + 4'd1;
                  end
                  if (bit_cnt == LAST_BIT) begin
                     done_set  = 1'b1;
                     nxt_state = ST_IDLE;
                  end
               end else if (tcnt >= TMAX) begin
                  tmo_set   = 1'b1;
                  nxt_state = ST_IDLE;
                  nxt_tcnt  = '0;
               end else begin
                  nxt_tcnt = tcnt + TW'(1);
               end
            end
            default: begin
               nxt_state = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      busy      = (state == ST_LATCH) || (state == ST_SHIFT);
      data      = (state == ST_IDLE) ? FILL : shreg[0];
      bit_count = (state == ST_SHIFT) ? bit_cnt : 4'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg      <= '0;
         bit_cnt    <= 4'd0;
         tcnt       <= '0;
         frame_done <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         shreg      <= nxt_shreg;
         bit_cnt    <= nxt_bit_cnt;
         tcnt       <= nxt_tcnt;
         frame_done <= done_set;
         timeout    <= tmo_set;
      end
   end

endmodule

// File: tb/tb_snes_controller_emu.sv
// Drives two emulators (FILL=0 and FILL=1) like a console and checks captured frames against a bit-level model.
module tb_snes_controller_emu;

   localparam int TMO = 2000;

   logic        clk = 1'b0;
   logic        reset;
   logic        latch;
   logic        sclk;
   logic [11:0] buttons;
   logic        data0, data1, busy0, busy1, fd0, fd1, to0, to1;
   logic [3:0]  bc0, bc1;

   int n_checks = 0;
   int n_errors = 0;
   int fd0_n = 0, fd1_n = 0, to0_n = 0, to1_n = 0;
   logic [14:0] cap0, cap1;
   int cap_idx;

   snes_controller_emu #(.TIMEOUT_CYCLES(TMO), .FILL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .latch(latch), .clock(sclk), .buttons(buttons),
      .data(data0), .busy(busy0), .bit_count(bc0), .frame_done(fd0), .timeout(to0));

   snes_controller_emu #(.TIMEOUT_CYCLES(TMO), .FILL(1'b1)) dut1 (
      .clk(clk), .reset(reset), .latch(latch), .clock(sclk), .buttons(buttons),
      .data(data1), .busy(busy1), .bit_count(bc1), .frame_done(fd1), .timeout(to1));

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (fd0) fd0_n++;
      if (fd1) fd1_n++;
      if (to0) to0_n++;
      if (to1) to1_n++;
   end

   // Bits 0..11 are the buttons, 12..14 carry the fill value.
   function automatic logic [14:0] exp_bits(input logic [11:0] btn, input logic fill);
      logic [14:0] e;
      for (int k = 0; k < 15; k++) begin
         if (k < 12) e[k] = btn[k];
         else        e[k] = fill;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Console samples data on each falling edge, then raises the clock to request the next bit.
   task automatic pulses(input int n, input int lo, input int hi, input bit chk);
      for (int k = 0; k < n; k++) begin
         if (cap_idx < 15) begin
            cap0[cap_idx] = data0;
            cap1[cap_idx] = data1;
         end
         if (chk) begin
            check("bit_count at fall", 32'(bc0), 32'(cap_idx));
            check("busy in frame", 32'(busy0), 32'(1));
         end
         cap_idx++;
         sclk = 1'b0;
         wait_cycles(lo);
         sclk = 1'b1;
         wait_cycles(hi);
      end
   endtask

   task automatic end_checks(input logic [11:0] btn, input int fd0_b, input int fd1_b,
                             input int to0_b, input string tag);
      check({tag, " captured fill0"}, 32'(cap0), 32'(exp_bits(btn, 1'b0)));
      check({tag, " captured fill1"}, 32'(cap1), 32'(exp_bits(btn, 1'b1)));
      check({tag, " frame_done fill0"}, 32'(fd0_n - fd0_b), 32'(1));
      check({tag, " frame_done fill1"}, 32'(fd1_n - fd1_b), 32'(1));
      check({tag, " no timeout"}, 32'(to0_n - to0_b), 32'(0));
      check({tag, " busy after"}, 32'({busy0, busy1}), 32'(0));
      check({tag, " idle data"}, 32'({data0, data1}), 32'(2'b01));
      check({tag, " idle bit_count"}, 32'({bc0, bc1}), 32'(0));
   endtask

   task automatic full_frame(input logic [11:0] btn, input logic [11:0] btn_late, input int lat_len,
                             input int lo, input int hi, input string tag);
      int fd0_b, fd1_b, to0_b;
      fd0_b = fd0_n; fd1_b = fd1_n; to0_b = to0_n;
      buttons = btn;
      latch = 1'b1;
      wait_cycles(lat_len);
      latch = 1'b0;
      wait_cycles(lo);
      buttons = btn_late;
      cap_idx = 0;
      pulses(15, lo, hi, 1'b1);
      end_checks(btn, fd0_b, fd1_b, to0_b, tag);
   endtask

   initial begin
      int fd0_b, fd1_b, to0_b, to1_b, elapsed, low_cnt;
      bit fired;
      logic [11:0] b, b2;

      reset = 1'b1; latch = 1'b0; sclk = 1'b1; buttons = 12'h000;
      wait_cycles(3);
      check("reset data", 32'({data0, data1}), 32'(2'b01));
      check("reset busy", 32'({busy0, busy1}), 32'(0));
      check("reset bit_count", 32'(bc0), 32'(0));
      check("reset pulses", 32'({fd0, to0, fd1, to1}), 32'(0));
      reset = 1'b0;
      wait_cycles(5);
      check("idle after reset", 32'({busy0, data0, data1, bc0}), 32'(6'b001_0000));

      // Nominal console timing.
      full_frame(12'hA5C, 12'hA5C, 600, 300, 300, "nominal");

      // Buttons change mid-frame and must not leak in.
      full_frame(12'h001, 12'hFFF, 40, 20, 20, "late buttons");

      // Timeout after 5 pulses with the clock parked high.
      fd0_b = fd0_n; to0_b = to0_n; to1_b = to1_n;
      latch = 1'b1; wait_cycles(30); latch = 1'b0; wait_cycles(20);
      cap_idx = 0;
      pulses(5, 20, 20, 1'b1);
      elapsed = 20;
      fired = 1'b0;
      for (int c = 0; c < 2500 && !fired; c++) begin
         wait_cycles(1);
         elapsed++;
         if (to0) fired = 1'b1;
      end
      check("timeout fired", 32'(fired), 32'(1));
      check("timeout not early", 32'(elapsed >= TMO), 32'(1));
      check("timeout not late", 32'(elapsed <= TMO + 8), 32'(1));
      wait_cycles(50);
      check("timeout pulses fill0", 32'(to0_n - to0_b), 32'(1));
      check("timeout pulses fill1", 32'(to1_n - to1_b), 32'(1));
      check("timeout no frame_done", 32'(fd0_n - fd0_b), 32'(0));
      check("timeout idle", 32'({busy0, data0, data1, bc0}), 32'(6'b001_0000));

      // Relatch after 7 pulses, with a console clock toggle while latch is high.
      b = 12'h3C6;
      buttons = 12'h5A5;
      latch = 1'b1; wait_cycles(30); latch = 1'b0; wait_cycles(20);
      cap_idx = 0;
      pulses(7, 20, 20, 1'b1);
      fd0_b = fd0_n; to0_b = to0_n; fd1_b = fd1_n;
      buttons = b;
      latch = 1'b1;
      low_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         if (c == 5) sclk = 1'b0;
         if (c == 15) sclk = 1'b1;
         wait_cycles(1);
         if (!busy0) low_cnt++;
      end
      check("relatch busy held", 32'(low_cnt), 32'(0));
      check("relatch bit_count", 32'(bc0), 32'(0));
      check("relatch data bit0", 32'(data0), 32'(b[0]));
      latch = 1'b0;
      wait_cycles(20);
      cap_idx = 0;
      pulses(15, 20, 20, 1'b1);
      end_checks(b, fd0_b, fd1_b, to0_b, "relatch");

      // Reset mid-frame; later clocks without a latch do nothing.
      fd0_b = fd0_n; to0_b = to0_n;
      buttons = 12'hF0F;
      latch = 1'b1; wait_cycles(30); latch = 1'b0; wait_cycles(20);
      cap_idx = 0;
      pulses(8, 20, 20, 1'b0);
      reset = 1'b1;
      wait_cycles(1);
      reset = 1'b0;
      wait_cycles(1);
      check("midreset idle", 32'({busy0, busy1, data0, data1, bc0, bc1}), 32'(12'b00_01_0000_0000));
      for (int k = 0; k < 5; k++) begin
         sclk = 1'b0; wait_cycles(20);
         sclk = 1'b1; wait_cycles(20);
         check("post-reset clocks ignored", 32'({busy0, data0, data1, bc0}), 32'(6'b001_0000));
      end
      check("post-reset no pulses", 32'((fd0_n - fd0_b) + (to0_n - to0_b)), 32'(0));

      for (int f = 0; f < 6; f++) begin
         b  = 12'($urandom);
         b2 = 12'($urandom);
         full_frame(b, b2, $urandom_range(10, 40), $urandom_range(5, 30), $urandom_range(5, 30), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
